pwm_combine: RTL
================

# pwm_combine

Final combiner and PWM output stage of the ANS-PWM chain. It takes the stage-1 unsigned quantizer value and the sign-magnitude correction terms from stages 2–4, and sums them in a 3-clock pipeline. The sum is saturated into the PWM range and double-buffered. A free-running period counter drives the modulator output `pwm` and paces the upstream chain through a per-period sample request.

## Interface
Parameters:
- `PWM_BITS`, default 8: period is 2^PWM_BITS clocks; legal duty range is 0..2^PWM_BITS.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid` in 1: one-clock strobe; sample all data inputs this cycle.
- `Q` in 16: stage-1 quantized value, unsigned.
- `C2`, `C3`, `C4` in 16 each: stage 2/3/4 correction magnitudes.
- `C2sgn`, `C3sgn`, `C4sgn` in 1 each: 1 = negative term.
- `req` out 1: one-clock pulse requesting the next sample from upstream.
- `pwm` out 1: modulated output.
- `sat` out 1: one-clock pulse when the latest result was clamped.
- `duty` out PWM_BITS+1: duty value active in the current period.

## Operation
- **Sign-magnitude conversion.**
  - Each Cn is converted to 19-bit two's complement: +mag if sgn=0, −mag if sgn=1.
  - sgn=1 with mag=0 yields 0.
  - Q is zero-extended to 19 bits.
- **Sum and range.** S = Q + C2 + C3 + C4 as a signed 19-bit value. The range is [−196605, 262140], so no internal overflow can occur.
- **Pipeline, advancing only with a valid token.**
  - P1: register the four converted operands plus the valid bit.
  - P2: register (Q+C2) and (C3+C4).
  - P3: final add, then saturate.
- **Saturation.**
  - S<0 gives 0.
  - S>2^PWM_BITS gives 2^PWM_BITS.
  - Otherwise the result is S.
  - The result is written to `shadow` with the P3 valid bit, and `sat` pulses in that same cycle if a clamp occurred.
- **Period counter.**
  - `cnt` (PWM_BITS wide) increments every clock and wraps from 2^PWM_BITS−1 to 0.
  - On the wrap edge, `duty` ← `shadow`. If no new sample arrived, the previous value is reloaded, so the last duty persists.
- **Output compare.**
  - `pwm` is a register, `pwm` ← (next cnt < duty used in next cycle).
  - The effect is that `pwm` is high for exactly `duty` clocks starting at cnt=0.
  - duty=0 gives constant low; duty=2^PWM_BITS gives constant high.
- **Request.** `req` is registered high for the single cycle where cnt==0, so upstream has a full period to deliver `valid`.

## Timing
- **Reset values.** All outputs are 0 and `cnt`=0, `shadow`=0, pipeline valid bits=0. The first `req` comes 1 clock after `rst_n` deasserts, coinciding with cnt=0 (counter starts counting).
- **Latency.** `valid` at edge k puts the result in `shadow` at edge k+3. `sat` is visible in the cycle after k+3.
- **Back-to-back valids.** These are accepted every clock; the last one before a wrap wins.
- **Shadow write coinciding with wrap.** If a shadow write lands on the same edge as the wrap, `duty` loads the OLD shadow value. The new value takes effect at the following wrap. There is no bypass.
- **Reset mid-period.** Asynchronous reset clears everything immediately: `pwm` drops low and in-flight pipeline tokens are discarded.
- **Inputs outside valid.** Data inputs are ignored when `valid`=0.

## Structure
- **Package `anspwm_pkg`.**
  - `DW`=16 (stage data width).
  - `SW`=19 (combiner sum width).
  - `typedef struct packed {logic sgn; logic [DW-1:0] mag;} sm16_t`.
  - Function `sat_duty(logic signed [SW-1:0] s, int bits)`.
- **Sub-module `sm2tc`.** A natural sub-module, instantiated three times: registered sign-magnitude to two's complement, with its own valid pass-through.
- **Top-level body.** The pipeline adders, shadow/duty double buffer, period counter, compare and req logic live in `pwm_combine` itself.

## Test plan
- **Reset.** Hold `rst_n`=0 → `pwm`/`req`/`sat`/`duty` all 0. Release → `req` pulse one clock later, then every 256 clocks.
- **Nominal sum.** Q=100, C2=5/+, C3=3/−, C4=0 → `shadow`=102 after 3 clocks, no `sat`. Next period `duty`=102 and `pwm` is high for exactly 102 of 256 clocks.
- **Underflow.** Q=10, C2=50/− → `shadow`=0 and `sat` pulses once. Next period `pwm` is constantly low.
- **Overflow.** Q=300, C2=C3=C4=0 → `shadow`=256 and `sat` pulses. Next period `pwm` is high for all 256 clocks, with no glitch at the wrap.
- **Wrap collision and persistence.** Issue `valid` 3 clocks before cnt wraps with Q=50, while `shadow`=20. The period starting at that wrap uses duty 20, and the following period uses 50. With no further `valid`, 50 persists.
- **Negative zero and reset mid-period.** Q=7, C3=0/− → duty 7. Asserting `rst_n`=0 while `pwm`=1 drives `pwm` low immediately. After release, `duty`=0.

Source files
------------

// File: rtl/anspwm_pkg.sv
// Shared widths, sign-magnitude operand type and duty saturation helper
// for the ANS-PWM combiner.
package anspwm_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 19;

  typedef struct packed {
    logic          sgn;
    logic [DW-1:0] mag;
  } sm16_t;

  // Clamp a signed sum into the legal duty range 0..2^bits.
  function automatic logic [SW-1:0] sat_duty(logic signed [SW-1:0] s, int bits);
    logic signed [SW-1:0] lim;
    lim = SW'(1 << bits);
    if (s < 0) begin
      sat_duty = '0;
    end else if (s > lim) begin
      sat_duty = lim;
    end else begin
      sat_duty = s;
    end
  endfunction

endpackage

// File: rtl/pwm_combine_sm2tc.sv
// Registered sign-magnitude to two's-complement converter with a valid
// pass-through; the data register only loads on a valid token.
module sm2tc
  import anspwm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  sm16_t                din,
  output logic signed [SW-1:0] tc_o,
  output logic                 valid_o
);

  logic signed [SW-1:0] tc_q, tc_d;
  logic                 valid_q, valid_d;

  // Convert on a valid token, otherwise hold; a negative zero yields zero.
  always_comb begin
    valid_d = valid_i;
    tc_d    = tc_q;
    if (valid_i) begin
      tc_d = din.sgn ? -SW'(din.mag) : SW'(din.mag);
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      tc_q    <= tc_d;
      valid_q <= valid_d;
    end
  end

  assign tc_o    = tc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pwm_combine.sv
// Final combiner and PWM output stage: 3-stage sum pipeline, saturation
// into a shadow register, per-period duty reload, compare and request.
module pwm_combine
  import anspwm_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [DW-1:0]       Q,
  input  logic [DW-1:0]       C2,
  input  logic [DW-1:0]       C3,
  input  logic [DW-1:0]       C4,
  input  logic                C2sgn,
  input  logic                C3sgn,
  input  logic                C4sgn,
  output logic                req,
  output logic                pwm,
  output logic                sat,
  output logic [PWM_BITS:0]   duty
);

  // P1: converted correction terms
  logic signed [SW-1:0] t2, t3, t4;
  logic                 v2o, v3o, v4o;
  logic                 v1;

  sm2tc u_c2 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid),
    .din({C2sgn, C2}), .tc_o(t2), .valid_o(v2o)
  );
  sm2tc u_c3 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid),
    .din({C3sgn, C3}), .tc_o(t3), .valid_o(v3o)
  );
  sm2tc u_c4 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid),
    .din({C4sgn, C4}), .tc_o(t4), .valid_o(v4o)
  );

  assign v1 = v2o & v3o & v4o;

  logic signed [SW-1:0] q1_q, q1_d;
  logic signed [SW-1:0] a2_q, a2_d, b2_q, b2_d;
  logic                 v2_q, v2_d;
  logic signed [SW-1:0] s3_q, s3_d;
  logic                 v3_q, v3_d;
  logic [PWM_BITS:0]    shadow_q, shadow_d;
  logic                 sat_q, sat_d;

  // Pipeline: each stage's data only advances alongside its valid token.
  always_comb begin
    q1_d     = valid ? SW'(Q) : q1_q;
    v2_d     = v1;
    a2_d     = a2_q;
    b2_d     = b2_q;
    if (v1) begin
      a2_d = q1_q + t2;
      b2_d = t3 + t4;
    end
    v3_d     = v2_q;
    s3_d     = v2_q ? (a2_q + b2_q) : s3_q;
    shadow_d = shadow_q;
    sat_d    = 1'b0;
    if (v3_q) begin
      shadow_d = (PWM_BITS+1)'(sat_duty(s3_q, PWM_BITS));
      sat_d    = ($signed(sat_duty(s3_q, PWM_BITS)) != s3_q);
    end
  end

  // Pipeline and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q     <= '0;
      a2_q     <= '0;
      b2_q     <= '0;
      v2_q     <= 1'b0;
      s3_q     <= '0;
      v3_q     <= 1'b0;
      shadow_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      q1_q     <= q1_d;
      a2_q     <= a2_d;
      b2_q     <= b2_d;
      v2_q     <= v2_d;
      s3_q     <= s3_d;
      v3_q     <= v3_d;
      shadow_q <= shadow_d;
      sat_q    <= sat_d;
    end
  end

  logic                run_q, run_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS:0]   duty_q, duty_d;
  logic                pwm_q, pwm_d;
  logic                req_q, req_d;
  logic                wrap;

  // Period counter, duty reload at wrap, compare and request.
  // The counter is held at 0 for the first clock after reset so that the
  // first request coincides with cnt==0 one clock after release; that
  // first edge is treated as a wrap. Compare uses next-cycle cnt/duty.
  always_comb begin
    run_d  = 1'b1;
    cnt_d  = run_q ? cnt_q + 1'b1 : '0;
    wrap   = (cnt_d == '0);
    duty_d = wrap ? shadow_q : duty_q;
    pwm_d  = ({1'b0, cnt_d} < duty_d);
    req_d  = wrap;
  end

  // Output stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      req_q  <= req_d;
    end
  end

  assign req  = req_q;
  assign pwm  = pwm_q;
  assign sat  = sat_q;
  assign duty = duty_q;

endmodule
